// File: rtl/alu_ctrl_issue_if.sv
// alu_ctrl_issue_if: decode-to-issue and issue-to-EX handshake bundle for the ALU ctrl slot
interface alu_ctrl_issue_if #(parameter int TAG_W = 5);
  logic [2:0]       alu_op_i;
  logic [5:0]       funct_i;
  logic [TAG_W-1:0] tag_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             flush_i;
  logic [3:0]       ctrl_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             mul_busy_o;
  modport master (
    output alu_op_i, funct_i, tag_i, in_valid_i, flush_i, out_ready_i,
    input  in_ready_o, ctrl_o, tag_o, illegal_o, out_valid_o, mul_busy_o
  );
  modport slave (
    input  alu_op_i, funct_i, tag_i, in_valid_i, flush_i, out_ready_i,
    output in_ready_o, ctrl_o, tag_o, illegal_o, out_valid_o, mul_busy_o
  );
endinterface

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes ALUOp/funct into a 4-bit ALU ctrl code and issues it through a one-entry slot
module alu_ctrl_issue #(
  parameter int MUL_LAT = 4
) (
  input logic              clk_i,
  input logic              rst_n,
  alu_ctrl_issue_if.slave  bus
);
  localparam int CW = $clog2(MUL_LAT) + 1;
  typedef enum logic [1:0] {EMPTY, FULL, MUL_WAIT} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    rdec;
  logic [3:0]    dec;
  logic          smul_held;
  logic          accept;
  // R-type funct to ctrl code; anything unlisted is illegal
  always_comb begin
    rdec = 4'd15;
    case (bus.funct_i)
      6'h24: rdec = 4'd0;
      6'h25: rdec = 4'd1;
      6'h21: rdec = 4'd4;
      6'h23: rdec = 4'd5;
      6'h2A: rdec = 4'd6;
      6'h2B: rdec = 4'd11;
      6'h00: rdec = 4'd12;
      6'h03: rdec = 4'd8;
      6'h07: rdec = 4'd9;
      6'h18: rdec = 4'd13;
      default: rdec = 4'd15;
    endcase
  end
  assign dec = bus.alu_op_i == 3'd0 ? 4'd2  :
               bus.alu_op_i == 3'd1 ? 4'd3  :
               bus.alu_op_i == 3'd3 ? 4'd7  :
               bus.alu_op_i == 3'd4 ? 4'd14 :
               bus.alu_op_i == 3'd5 ? 4'd10 :
               bus.alu_op_i == 3'd6 ? 4'd4  :
               bus.alu_op_i == 3'd7 ? 4'd11 : rdec;
  // a pending SMUL must leave alone so its ALU occupancy can start cleanly
  assign smul_held     = state == FULL && bus.ctrl_o == 4'd13 && MUL_LAT > 1;
  assign bus.in_ready_o = !bus.flush_i &&
                          (state == EMPTY || (state == FULL && bus.out_ready_i && !smul_held));
  assign accept        = bus.in_valid_i && bus.in_ready_o;
  // issue-slot FSM with registered outputs and SMUL occupancy counter
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state           <= EMPTY;
      cnt             <= '0;
      bus.ctrl_o      <= '0;
      bus.tag_o       <= '0;
      bus.illegal_o   <= 1'b0;
      bus.out_valid_o <= 1'b0;
      bus.mul_busy_o  <= 1'b0;
    end else if (bus.flush_i) begin
      state           <= EMPTY;
      cnt             <= '0;
      bus.out_valid_o <= 1'b0;
      bus.mul_busy_o  <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state           <= FULL;
          bus.ctrl_o      <= dec;
          bus.tag_o       <= bus.tag_i;
          bus.illegal_o   <= dec == 4'd15;
          bus.out_valid_o <= 1'b1;
        end
        FULL: if (bus.out_ready_i) begin
          if (smul_held) begin
            state           <= MUL_WAIT;
            cnt             <= CW'(MUL_LAT - 1);
            bus.out_valid_o <= 1'b0;
            bus.mul_busy_o  <= 1'b1;
          end else if (accept) begin
            bus.ctrl_o    <= dec;
            bus.tag_o     <= bus.tag_i;
            bus.illegal_o <= dec == 4'd15;
          end else begin
            state           <= EMPTY;
            bus.out_valid_o <= 1'b0;
          end
        end
        MUL_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state          <= EMPTY;
            bus.mul_busy_o <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: directed scenarios plus randomized traffic checked against a slot/hold reference model
module tb_alu_ctrl_issue;
  localparam int MUL_LAT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  alu_ctrl_issue_if #(.TAG_W(5)) bus();
  alu_ctrl_issue #(.MUL_LAT(MUL_LAT)) dut (.clk_i(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int op_code [8]  = '{2, 3, -1, 7, 14, 10, 4, 11};
  int fn_list [10] = '{'h24, 'h25, 'h21, 'h23, 'h2A, 'h2B, 'h00, 'h03, 'h07, 'h18};
  int fn_code [10] = '{0, 1, 4, 5, 6, 11, 12, 8, 9, 13};
  bit         m_valid;
  logic [3:0] m_ctrl;
  logic [4:0] m_tag;
  int         m_hold;
  function automatic logic [3:0] ref_dec(int op, int f);
    if (op != 2) return 4'(op_code[op]);
    for (int i = 0; i < 10; i++) if (f == fn_list[i]) return 4'(fn_code[i]);
    return 4'd15;
  endfunction
  function automatic bit exp_ready();
    return !bus.flush_i && m_hold == 0 && (!m_valid || (bus.out_ready_i && m_ctrl != 4'd13));
  endfunction
  task automatic tick();
    bit acc;
    acc = bus.in_valid_i && exp_ready();
    if (!rst_n) begin
      m_valid = 0; m_hold = 0; m_ctrl = 0; m_tag = 0;
    end else if (bus.flush_i) begin
      m_valid = 0; m_hold = 0;
    end else begin
      if (m_hold > 0) m_hold--;
      if (m_valid && bus.out_ready_i) begin
        if (m_ctrl == 4'd13) m_hold = MUL_LAT - 1;
        m_valid = 0;
      end
      if (acc) begin
        m_valid = 1;
        m_ctrl  = ref_dec(int'(bus.alu_op_i), int'(bus.funct_i));
        m_tag   = bus.tag_i;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn, input logic [4:0] tg);
    bus.in_valid_i = v; bus.alu_op_i = op; bus.funct_i = fn; bus.tag_i = tg;
  endtask
  task automatic test_reset();
    rst_n = 0; bus.flush_i = 0; bus.out_ready_i = 1;
    drive(0, 0, 0, 0);
    tick(); tick();
    rst_n = 1;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid_o); end
    checks++; if (bus.ctrl_o !== 4'd0 || bus.tag_o !== 5'd0) begin errs++; $display("FAIL reset_ctrl_tag got=%0d/%0d want=0/0", bus.ctrl_o, bus.tag_o); end
    checks++; if (bus.illegal_o !== 1'b0 || bus.mul_busy_o !== 1'b0) begin errs++; $display("FAIL reset_flags got=%0b/%0b want=0/0", bus.illegal_o, bus.mul_busy_o); end
    checks++; if (bus.in_ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready got=%0b want=1", bus.in_ready_o); end
  endtask
  task automatic test_addu();
    drive(1, 3'b010, 6'h21, 5'd3);
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.ctrl_o !== 4'd4 || bus.tag_o !== 5'd3 || bus.out_valid_o !== 1'b1) begin errs++; $display("FAIL addu got=%0d/%0d/%0b want=4/3/1", bus.ctrl_o, bus.tag_o, bus.out_valid_o); end
    tick();
    checks++; if (bus.out_valid_o !== 1'b0) begin errs++; $display("FAIL addu_drain got=%0b want=0", bus.out_valid_o); end
  endtask
  task automatic test_stream();
    logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [3:0] exp [7] = '{4'd2, 4'd3, 4'd7, 4'd14, 4'd10, 4'd4, 4'd11};
    for (int i = 0; i < 7; i++) begin
      drive(1, ops[i], 6'h3F, 5'(i + 10));
      tick();
      checks++; if (bus.ctrl_o !== exp[i] || bus.tag_o !== 5'(i + 10) || bus.out_valid_o !== 1'b1) begin errs++; $display("FAIL stream[%0d] got=%0d/%0d/%0b want=%0d/%0d/1", i, bus.ctrl_o, bus.tag_o, bus.out_valid_o, exp[i], i + 10); end
    end
    drive(0, 0, 0, 0);
    tick();
  endtask
  task automatic test_smul();
    drive(1, 3'b010, 6'h18, 5'd6);
    tick();
    drive(1, 3'b110, 6'h00, 5'd8);
    #1;
    checks++; if (bus.ctrl_o !== 4'd13 || bus.in_ready_o !== 1'b0) begin errs++; $display("FAIL smul_full got=%0d/%0b want=13/0", bus.ctrl_o, bus.in_ready_o); end
    tick();
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      checks++; if (bus.mul_busy_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin errs++; $display("FAIL smul_wait[%0d] got=%0b/%0b/%0b want=1/0/0", i, bus.mul_busy_o, bus.in_ready_o, bus.out_valid_o); end
      tick();
    end
    checks++; if (bus.mul_busy_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin errs++; $display("FAIL smul_release got=%0b/%0b want=0/1", bus.mul_busy_o, bus.in_ready_o); end
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.ctrl_o !== 4'd4 || bus.tag_o !== 5'd8 || bus.out_valid_o !== 1'b1) begin errs++; $display("FAIL smul_next got=%0d/%0d/%0b want=4/8/1", bus.ctrl_o, bus.tag_o, bus.out_valid_o); end
    tick();
  endtask
  task automatic test_backpressure();
    bus.out_ready_i = 0;
    drive(1, 3'b010, 6'h21, 5'd7);
    tick();
    drive(1, 3'b000, 6'h00, 5'd9);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.in_ready_o !== 1'b0 || bus.ctrl_o !== 4'd4 || bus.tag_o !== 5'd7 || bus.out_valid_o !== 1'b1) begin errs++; $display("FAIL stall[%0d] got=%0b/%0d/%0d/%0b want=0/4/7/1", i, bus.in_ready_o, bus.ctrl_o, bus.tag_o, bus.out_valid_o); end
      tick();
    end
    bus.out_ready_i = 1;
    #1;
    checks++; if (bus.in_ready_o !== 1'b1) begin errs++; $display("FAIL stall_release got=%0b want=1", bus.in_ready_o); end
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.ctrl_o !== 4'd2 || bus.tag_o !== 5'd9 || bus.out_valid_o !== 1'b1) begin errs++; $display("FAIL stall_b2b got=%0d/%0d/%0b want=2/9/1", bus.ctrl_o, bus.tag_o, bus.out_valid_o); end
    tick();
  endtask
  task automatic test_illegal();
    drive(1, 3'b010, 6'h3F, 5'd1);
    tick();
    checks++; if (bus.ctrl_o !== 4'd15 || bus.illegal_o !== 1'b1 || bus.out_valid_o !== 1'b1) begin errs++; $display("FAIL illegal got=%0d/%0b/%0b want=15/1/1", bus.ctrl_o, bus.illegal_o, bus.out_valid_o); end
    drive(1, 3'b000, 6'h3F, 5'd2);
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.ctrl_o !== 4'd2 || bus.illegal_o !== 1'b0) begin errs++; $display("FAIL illegal_clear got=%0d/%0b want=2/0", bus.ctrl_o, bus.illegal_o); end
    tick();
  endtask
  task automatic test_flush_reset();
    drive(1, 3'b010, 6'h18, 5'd4);
    tick();
    drive(0, 0, 0, 0);
    tick();
    tick();
    bus.flush_i = 1;
    #1;
    checks++; if (bus.mul_busy_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin errs++; $display("FAIL flush_pre got=%0b/%0b want=1/0", bus.mul_busy_o, bus.in_ready_o); end
    tick();
    bus.flush_i = 0;
    #1;
    checks++; if (bus.mul_busy_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin errs++; $display("FAIL flush_post got=%0b/%0b/%0b want=0/0/1", bus.mul_busy_o, bus.out_valid_o, bus.in_ready_o); end
    drive(1, 3'b101, 6'h00, 5'd5);
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.ctrl_o !== 4'd10 || bus.out_valid_o !== 1'b1) begin errs++; $display("FAIL flush_refill got=%0d/%0b want=10/1", bus.ctrl_o, bus.out_valid_o); end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if (bus.ctrl_o !== 4'd0 || bus.tag_o !== 5'd0 || bus.illegal_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.mul_busy_o !== 1'b0) begin errs++; $display("FAIL mid_reset got=%0d/%0d/%0b/%0b/%0b want=all 0", bus.ctrl_o, bus.tag_o, bus.illegal_o, bus.out_valid_o, bus.mul_busy_o); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0 ? 6'(fn_list[$urandom_range(0, 9)]) : 6'($urandom_range(0, 63)),
            5'($urandom_range(0, 31)));
      bus.out_ready_i = $urandom_range(0, 3) != 0;
      bus.flush_i     = $urandom_range(0, 15) == 0;
      #1;
      checks++; if (bus.in_ready_o !== exp_ready()) begin errs++; $display("FAIL rnd_ready[%0d] got=%0b want=%0b", n, bus.in_ready_o, exp_ready()); end
      tick();
      checks++; if (bus.out_valid_o !== m_valid || bus.mul_busy_o !== (m_hold > 0)) begin errs++; $display("FAIL rnd_state[%0d] got=%0b/%0b want=%0b/%0b", n, bus.out_valid_o, bus.mul_busy_o, m_valid, m_hold > 0); end
      if (m_valid) begin
        checks++; if (bus.ctrl_o !== m_ctrl || bus.tag_o !== m_tag || bus.illegal_o !== (m_ctrl == 4'd15)) begin errs++; $display("FAIL rnd_data[%0d] got=%0d/%0d/%0b want=%0d/%0d/%0b", n, bus.ctrl_o, bus.tag_o, bus.illegal_o, m_ctrl, m_tag, m_ctrl == 4'd15); end
      end
    end
    bus.flush_i = 0;
    drive(0, 0, 0, 0);
  endtask
  initial begin
    test_reset();
    test_addu();
    test_stream();
    test_smul();
    test_backpressure();
    test_illegal();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
